// File: rtl/rv_dmem_pkg.sv
// Shared encodings and sizing for the doubleword data-memory controller.
package rv_dmem_pkg;

    localparam int DEPTH_DEF = 4096;
    localparam int IDX_W     = $clog2(DEPTH_DEF);

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // An access is aligned when the low address bits inside its own size are zero.
    function automatic logic is_aligned(input logic [2:0] off, input size_e sz);
        case (sz)
            SZ_B:    return 1'b1;
            SZ_H:    return ~off[0];
            SZ_W:    return off[1:0] == 2'b00;
            default: return off == 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/rv_dmem_ctrl_if.sv
// Request/response and memory-side bundle of rv_dmem_ctrl.
interface rv_dmem_ctrl_if;

    // Handshake: a request on port i is accepted in any cycle where
    // req_valid[i] & req_ready[i]; responses are single-cycle pulses with no backpressure.
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        req_we_0;
    logic        req_we_1;
    logic [1:0]  req_size_0;
    logic [1:0]  req_size_1;
    logic        req_unsigned_0;
    logic        req_unsigned_1;
    logic [63:0] req_addr_0;
    logic [63:0] req_addr_1;
    logic [63:0] req_wdata_0;
    logic [63:0] req_wdata_1;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [63:0] rsp_rdata;
    logic [63:0] mem_addr;
    logic        mem_wr_en;
    logic [63:0] mem_wr_data;
    logic        mem_rd_en;
    logic [63:0] mem_rd_data;

    modport slave (
        input  req_valid, req_we_0, req_we_1, req_size_0, req_size_1,
               req_unsigned_0, req_unsigned_1, req_addr_0, req_addr_1,
               req_wdata_0, req_wdata_1, mem_rd_data,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
               mem_addr, mem_wr_en, mem_wr_data, mem_rd_en
    );

    modport master (
        output req_valid, req_we_0, req_we_1, req_size_0, req_size_1,
               req_unsigned_0, req_unsigned_1, req_addr_0, req_addr_1,
               req_wdata_0, req_wdata_1, mem_rd_data,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
               mem_addr, mem_wr_en, mem_wr_data, mem_rd_en
    );

endinterface

// File: rtl/rv_dmem_lane.sv
// Byte-lane logic: store-data insertion into a read word and load shift/extend.
module rv_dmem_lane
    import rv_dmem_pkg::*;
(
    input  logic [63:0] rd_word_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] cap_word_i,
    input  logic [2:0]  off_i,
    input  size_e       size_i,
    input  logic        uns_i,
    output logic [63:0] merged_o,
    output logic [63:0] load_o
);

    logic [5:0]  sh;
    logic [63:0] mask;
    logic [63:0] shifted;

    always_comb begin
        sh      = {off_i, 3'b000};
        mask    = '1;
        shifted = cap_word_i >> sh;
        load_o  = shifted;
        case (size_i)
            SZ_B: begin
                mask   = 64'h0000_0000_0000_00FF;
                load_o = uns_i ? {56'b0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                mask   = 64'h0000_0000_0000_FFFF;
                load_o = uns_i ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                mask   = 64'h0000_0000_FFFF_FFFF;
                load_o = uns_i ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            end
            default: begin
                mask   = '1;
                load_o = shifted;
            end
        endcase
        merged_o = (rd_word_i & ~(mask << sh)) | ((wdata_i & mask) << sh);
    end

endmodule

// File: rtl/rv_dmem_ctrl.sv
// Two-port round-robin controller for a 64-bit synchronous data memory.
// Optional RV_DMEM_BOUNDS_CHK_EN rejects doubleword indices >= DEPTH with rsp_err.
module rv_dmem_ctrl
    import rv_dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    rv_dmem_ctrl_if.slave            bus,
    output state_e                   dbg_state_o,
    output logic [$clog2(DEPTH)-1:0] dbg_idx_o
);

    localparam int IW = $clog2(DEPTH);

    state_e      state_q, state_d;
    logic        rr_ptr_q;
    logic        port_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] word_q;
    size_e       size_q;
    logic        we_q;
    logic        uns_q;
    logic        err_q;

    logic [1:0]  grant;
    logic        sel;
    logic        acc;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    size_e       sel_size;
    logic        sel_we;
    logic        sel_uns;
    logic        sel_oob;
    logic        sel_err;
    logic [63:0] merged;
    logic [63:0] load_data;

    // rr_ptr_q names the preferred port when both request; a lone requester always wins.
    always_comb begin
        grant[0]  = bus.req_valid[0] & (~bus.req_valid[1] | ~rr_ptr_q);
        grant[1]  = bus.req_valid[1] & (~bus.req_valid[0] | rr_ptr_q);
        sel       = grant[1];
        acc       = rst_n & (state_q == ST_IDLE) & (|grant);
        sel_addr  = sel ? bus.req_addr_1 : bus.req_addr_0;
        sel_wdata = sel ? bus.req_wdata_1 : bus.req_wdata_0;
        sel_size  = size_e'(sel ? bus.req_size_1 : bus.req_size_0);
        sel_we    = sel ? bus.req_we_1 : bus.req_we_0;
        sel_uns   = sel ? bus.req_unsigned_1 : bus.req_unsigned_0;
`ifdef RV_DMEM_BOUNDS_CHK_EN
        sel_oob   = sel_addr[63:3] >= 61'(DEPTH);
`else
        sel_oob   = 1'b0;
`endif
        sel_err   = ~is_aligned(sel_addr[2:0], sel_size) | sel_oob;
    end

    always_comb begin
        state_d         = state_q;
        bus.req_ready   = '0;
        bus.rsp_valid   = '0;
        bus.rsp_err     = 1'b0;
        bus.rsp_rdata   = '0;
        bus.mem_addr    = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = '0;
        bus.mem_rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = rst_n ? grant : 2'b00;
                if (acc) begin
                    if (sel_err)                        state_d = ST_RESP;
                    else if (sel_we && sel_size == SZ_D) state_d = ST_WR;
                    else                                 state_d = ST_RD;
                end
            end
            ST_RD: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = {3'b000, addr_q[63:3]};
                state_d       = ST_CAP;
            end
            ST_CAP: begin
                bus.mem_addr = {3'b000, addr_q[63:3]};
                state_d      = we_q ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = {3'b000, addr_q[63:3]};
                bus.mem_wr_data = (size_q == SZ_D) ? wdata_q : word_q;
                state_d         = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid[port_q] = 1'b1;
                bus.rsp_err           = err_q;
                bus.rsp_rdata         = (we_q | err_q) ? 64'd0 : load_data;
                state_d               = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
            port_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
            size_q   <= SZ_B;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (acc) begin
                rr_ptr_q <= ~sel;
                port_q   <= sel;
                addr_q   <= sel_addr;
                wdata_q  <= sel_wdata;
                size_q   <= sel_size;
                we_q     <= sel_we;
                uns_q    <= sel_uns;
                err_q    <= sel_err;
            end
            // Loads keep the raw word; sub-dword stores keep the merged word for WR.
            if (state_q == ST_CAP) word_q <= we_q ? merged : bus.mem_rd_data;
        end
    end

    rv_dmem_lane u_lane (
        .rd_word_i  (bus.mem_rd_data),
        .wdata_i    (wdata_q),
        .cap_word_i (word_q),
        .off_i      (addr_q[2:0]),
        .size_i     (size_q),
        .uns_i      (uns_q),
        .merged_o   (merged),
        .load_o     (load_data)
    );

    assign dbg_state_o = state_q;
    assign dbg_idx_o   = addr_q[3 +: IW];

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// Self-checking bench for rv_dmem_ctrl against a byte-addressed reference memory.
// Expectations follow RV_DMEM_BOUNDS_CHK_EN when it is defined for the build.
module tb_rv_dmem_ctrl;
    import rv_dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        preload_go;
    state_e      dbg_state;
    logic [IDX_W-1:0] dbg_idx;

    int n_total;
    int n_bad;

    logic [63:0] tb_mem [0:4095];
    logic [7:0]  ref_b  [0:32767];
    logic [63:0] exp_q [$];
    logic [0:0]  exp_port_q [$];

    logic [63:0] last_rdata;
    logic [63:0] last_wr_word;
    logic        last_err;

    rv_dmem_ctrl_if bus ();

    rv_dmem_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state),
        .dbg_idx_o   (dbg_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input int i);
        logic [31:0] x;
        x = 32'(i) * 32'h9E37_79B1 + 32'h7F4A_7C15;
        return {x ^ 32'hA5A5_0F0F, ~x};
    endfunction

    always @(posedge clk) begin
        if (preload_go) begin
            for (int i = 0; i < 4096; i++) tb_mem[i] <= init_word(i);
        end else begin
            if (bus.mem_wr_en) tb_mem[bus.mem_addr[11:0]] <= bus.mem_wr_data;
            if (bus.mem_rd_en) bus.mem_rd_data <= tb_mem[bus.mem_addr[11:0]];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_word(input logic [63:0] a);
        logic [63:0] v;
        int base;
        base = int'({a[14:3], 3'b000});
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_b[base + i];
        return v;
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz, input logic uns);
        logic [63:0] v;
        int n;
        int base;
        n    = 1 << sz;
        base = int'(a[14:0]);
        v    = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[base + i];
        if (!uns && n < 8 && v[8*n-1]) begin
            for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
        int n;
        int base;
        n    = 1 << sz;
        base = int'(a[14:0]);
        for (int i = 0; i < n; i++) ref_b[base + i] = wd[8*i +: 8];
    endtask

    task automatic set_port(input int p, input logic we, input logic [1:0] sz, input logic uns,
                            input logic [63:0] a, input logic [63:0] wd);
        if (p == 0) begin
            bus.req_we_0 = we; bus.req_size_0 = sz; bus.req_unsigned_0 = uns;
            bus.req_addr_0 = a; bus.req_wdata_0 = wd;
        end else begin
            bus.req_we_1 = we; bus.req_size_1 = sz; bus.req_unsigned_1 = uns;
            bus.req_addr_1 = a; bus.req_wdata_1 = wd;
        end
    endtask

    // One complete transaction on port p; called at a falling edge with the DUT idle or in RESP.
    task automatic do_req(input int p, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [63:0] a, input logic [63:0] wd);
        logic        exp_err;
        logic [63:0] exp_wr;
        int          n, exp_lat, exp_nrd, exp_nwr, waits, n_rd, n_wr, lat;
        n       = 1 << sz;
        exp_err = (a[2:0] & 3'(n - 1)) != 3'b000;
`ifdef RV_DMEM_BOUNDS_CHK_EN
        if (a[63:3] >= 61'd4096) exp_err = 1'b1;
`endif
        exp_wr = '0;
        if (exp_err) begin
            exp_lat = 1; exp_nrd = 0; exp_nwr = 0; exp_q.push_back(64'd0);
        end else if (!we) begin
            exp_lat = 3; exp_nrd = 1; exp_nwr = 0; exp_q.push_back(ref_load(a, sz, uns));
        end else begin
            ref_store(a, sz, wd);
            exp_wr  = ref_word(a);
            exp_lat = (n == 8) ? 2 : 4;
            exp_nrd = (n == 8) ? 0 : 1;
            exp_nwr = 1;
            exp_q.push_back(64'd0);
        end
        set_port(p, we, sz, uns, a, wd);
        bus.req_valid[p] = 1'b1;
        #1;
        waits = 0;
        while (!bus.req_ready[p] && waits < 20) begin
            @(negedge clk); #1;
            waits++;
        end
        check_val("accept_seen", 64'(bus.req_ready[p]), 64'd1);
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
        n_rd = 0; n_wr = 0; lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_val("rd_wr_excl", 64'(bus.mem_rd_en & bus.mem_wr_en), 64'd0);
            if (bus.mem_rd_en) begin
                n_rd++;
                check_val("rd_cycle", 64'(k), 64'd1);
                check_val("rd_index", bus.mem_addr, a >> 3);
            end
            if (bus.mem_wr_en) begin
                n_wr++;
                last_wr_word = bus.mem_wr_data;
                check_val("wr_cycle", 64'(k), 64'(exp_lat - 1));
                check_val("wr_index", bus.mem_addr, a >> 3);
                check_val("wr_word", bus.mem_wr_data, exp_wr);
            end
            if (bus.rsp_valid != 2'b00) begin
                lat        = k;
                last_rdata = bus.rsp_rdata;
                last_err   = bus.rsp_err;
                check_val("rsp_port", 64'(bus.rsp_valid), 64'(2'b01 << p));
                check_val("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
                check_val("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
                break;
            end
        end
        check_val("rsp_latency", 64'(lat), 64'(exp_lat));
        check_val("rd_count", 64'(n_rd), 64'(exp_nrd));
        check_val("wr_count", 64'(n_wr), 64'(exp_nwr));
        if (lat == 0) exp_q.delete();
    endtask

    task automatic arb_test();
        int n_acc, n_rsp;
        logic [0:0] port;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        set_port(0, 1'b0, 2'b11, 1'b0, 64'h10, 64'd0);
        set_port(1, 1'b0, 2'b10, 1'b0, 64'h1C, 64'd0);
        bus.req_valid = 2'b11;
        #1;
        n_acc = 0; n_rsp = 0;
        for (int c = 0; c < 80 && n_rsp < 4; c++) begin
            if (bus.rsp_valid != 2'b00) begin
                port = exp_port_q.pop_front();
                check_val("arb_rsp_port", 64'(bus.rsp_valid), 64'(2'b01 << port));
                check_val("arb_rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
                n_rsp++;
            end
            if (bus.req_ready != 2'b00 && n_acc < 4) begin
                check_val("arb_onehot", 64'($countones(bus.req_ready)), 64'd1);
                port = bus.req_ready[1];
                check_val("arb_order", 64'(port), 64'(n_acc % 2));
                exp_port_q.push_back(port);
                exp_q.push_back(port ? ref_load(64'h1C, 2'b10, 1'b0) : ref_load(64'h10, 2'b11, 1'b0));
                n_acc++;
                if (n_acc == 4) begin
                    @(posedge clk); #1;
                    bus.req_valid = 2'b00;
                end
            end
            @(negedge clk); #1;
        end
        check_val("arb_rsp_count", 64'(n_rsp), 64'd4);
        exp_q.delete();
        exp_port_q.delete();
    endtask

    task automatic reset_cap_test();
        logic [63:0] wd;
        @(negedge clk);
        wd = {56'd0, ~ref_b[16'h21]};
        set_port(0, 1'b1, 2'b00, 1'b0, 64'h21, wd);
        bus.req_valid = 2'b01;
        #1;
        check_val("rc_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check_val("rc_rd_en", 64'(bus.mem_rd_en), 64'd1);
        @(negedge clk);
        check_val("rc_in_cap", 64'(dbg_state), 64'(ST_CAP));
        bus.req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        check_val("rc_ready0", 64'(bus.req_ready), 64'd0);
        check_val("rc_state", 64'(dbg_state), 64'(ST_IDLE));
        check_val("rc_addr0", bus.mem_addr, 64'd0);
        check_val("rc_rsp0", 64'({bus.rsp_valid, bus.rsp_err}), 64'd0);
        check_val("rc_rdata0", bus.rsp_rdata, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("rc_no_wr", 64'({bus.mem_wr_en, bus.mem_rd_en}), 64'd0);
        end
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
        do_req(0, 1'b0, 2'b11, 1'b0, 64'h20, 64'd0);
        check_val("rc_word_kept", last_rdata, ref_word(64'h20));
    endtask

    initial begin
        logic [63:0] a, wd;
        logic [1:0]  sz;
        int          n;
        n_total = 0; n_bad = 0;
        rst_n = 1'b0; preload_go = 1'b1;
        bus.req_valid = 2'b00;
        set_port(0, 1'b0, 2'b00, 1'b0, 64'd0, 64'd0);
        set_port(1, 1'b0, 2'b00, 1'b0, 64'd0, 64'd0);
        for (int i = 0; i < 4096; i++) begin
            wd = init_word(i);
            for (int b = 0; b < 8; b++) ref_b[i*8 + b] = wd[8*b +: 8];
        end
        repeat (2) @(posedge clk);
        #1 preload_go = 1'b0;

        bus.req_valid = 2'b11;
        #1;
        check_val("rst_ready", 64'(bus.req_ready), 64'd0);
        check_val("rst_rsp", 64'({bus.rsp_valid, bus.rsp_err}), 64'd0);
        check_val("rst_mem_en", 64'({bus.mem_rd_en, bus.mem_wr_en}), 64'd0);
        check_val("rst_addr", bus.mem_addr, 64'd0);
        check_val("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        bus.req_valid = 2'b00;
        @(negedge clk); rst_n = 1'b1;
        #1;
        check_val("idle_ready", 64'(bus.req_ready), 64'd0);

        do_req(0, 1'b1, 2'b11, 1'b0, 64'h10, 64'h1122_3344_5566_7788);
        check_val("plan_sd_word", last_wr_word, 64'h1122_3344_5566_7788);
        do_req(0, 1'b0, 2'b11, 1'b0, 64'h10, 64'd0);
        check_val("plan_ld", last_rdata, 64'h1122_3344_5566_7788);
        do_req(0, 1'b1, 2'b00, 1'b0, 64'h13, 64'hAB);
        check_val("plan_sb_word", last_wr_word, 64'h1122_3344_AB66_7788);
        do_req(1, 1'b0, 2'b00, 1'b1, 64'h13, 64'd0);
        check_val("plan_lbu", last_rdata, 64'h0000_0000_0000_00AB);
        do_req(1, 1'b0, 2'b00, 1'b0, 64'h13, 64'd0);
        check_val("plan_lb", last_rdata, 64'hFFFF_FFFF_FFFF_FFAB);
        do_req(0, 1'b0, 2'b10, 1'b0, 64'h12, 64'd0);
        check_val("plan_lw_mis", 64'(last_err), 64'd1);
        do_req(1, 1'b0, 2'b11, 1'b0, 64'h8000, 64'd0);
`ifdef RV_DMEM_BOUNDS_CHK_EN
        check_val("plan_oob_err", 64'(last_err), 64'd1);
`else
        check_val("plan_oob_wrap", last_rdata, ref_word(64'h0));
`endif

        for (int it = 0; it < 200; it++) begin
            sz = 2'($urandom_range(0, 3));
            n  = 1 << sz;
            a  = 64'($urandom_range(0, 15)) << 3;
            if ($urandom_range(0, 4) == 0) a[2:0] = 3'($urandom_range(0, 7));
            else                           a[2:0] = 3'($urandom_range(0, 7)) & ~3'(n - 1);
            if ($urandom_range(0, 9) == 0) a = a | (64'($urandom) << 15);
            wd = {$urandom, $urandom};
            do_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
                   1'($urandom_range(0, 1)), a, wd);
        end

        arb_test();
        reset_cap_test();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_dmem_ctrl.md
Name: rv_dmem_ctrl

Overview:
Two-port controller in front of the 64-bit data memory (4096 x 64, synchronous read, no byte enables). Arbitrates between the core LSU (port 0) and the debug/DMA port (port 1), one transaction at a time.
Converts byte/half/word/dword requests into doubleword-indexed memory accesses. Sub-dword stores use read-modify-write; load data is aligned and sign/zero-extended.

Parameters:
DEPTH, 4096, memory depth in doublewords; index width = clog2(DEPTH)
NPORT, 2, number of requesters; fixed at 2, port 0 = LSU, port 1 = debug/DMA

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-port request valid
req_ready  out  2  per-port accept; a request is accepted in a cycle where req_valid[i] & req_ready[i]
req_we_0 / req_we_1  in  1  1 = store, 0 = load
req_size_0 / req_size_1  in  2  00 = B, 01 = H, 10 = W, 11 = D
req_unsigned_0 / req_unsigned_1  in  1  zero-extend load
req_addr_0 / req_addr_1  in  64  byte address
req_wdata_0 / req_wdata_1  in  64  store data, LSB-aligned
rsp_valid  out  2  one-cycle response pulse per port; no backpressure
rsp_err  out  1  misaligned access, or out-of-range access when the optional feature is compiled in
rsp_rdata  out  64  extended load data; 0 for stores and errors
mem_addr  out  64  doubleword index = {3'b0, addr[63:3]}
mem_wr_en  out  1  memory write enable
mem_wr_data  out  64  memory write data
mem_rd_en  out  1  memory read enable
mem_rd_data  in  64  memory read data, valid the cycle after mem_rd_en

Behaviour:
- Reset (asynchronous): state = IDLE, rr_ptr = 0, all outputs 0 including req_ready. Any in-flight transaction is dropped with no response and no memory write.
- req_ready[i] = (state == IDLE) & grant[i]; at most one bit set.
- Arbitration is round-robin on simultaneous valid.
  - rr_ptr names the preferred port.
  - After each accept, rr_ptr = the other port.
  - A single valid requester is always granted.
- Accepting a request registers addr, size, we, wdata, unsigned and port id.
- Alignment rule: aligned when addr mod (1 << size) == 0. A misaligned request goes IDLE -> RESP with rsp_err = 1 and makes no memory access.
- State machine, with A = the accept cycle:
  - Load: IDLE -> RD (A+1: mem_rd_en = 1) -> CAP (A+2: capture mem_rd_data) -> RESP (A+3: rsp_valid). Latency is 3 cycles.
  - Dword store: IDLE -> WR (A+1: mem_wr_en = 1, mem_wr_data = wdata) -> RESP (A+2).
  - Sub-dword store: IDLE -> RD (A+1) -> CAP (A+2: merge the captured word with wdata in lanes addr[2:0]..addr[2:0]+bytes-1) -> WR (A+3) -> RESP (A+4).
- RESP lasts one cycle, then returns to IDLE; a new accept is possible the cycle after RESP.
- Load extraction:
  - Shift the captured word right by 8*addr[2:0].
  - Truncate to the access size.
  - Sign-extend from the top bit unless unsigned; D ignores unsigned.
- mem_addr holds the latched index throughout RD, CAP and WR; it is 0 in IDLE.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- The unused upper mem_addr bits alias (the memory uses only the low clog2(DEPTH) bits).

Optional Feature:
- Macro: RV_DMEM_BOUNDS_CHK_EN.
- Defined: addr[63:3] >= DEPTH is treated like a misaligned request: rsp_err = 1, no memory access, latency 1 (accept -> RESP).
- Undefined: no range check; out-of-range addresses wrap modulo DEPTH doublewords.

Decomposition:
- Package rv_dmem_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - state encodings ST_IDLE/ST_RD/ST_CAP/ST_WR/ST_RESP
  - the DEPTH default and derived index width
- One sub-module, rv_dmem_lane: combinational merge (store byte-lane insertion) and extract (load shift/extend), instantiated once.
- The FSM and arbiter stay in rv_dmem_ctrl.

Test Plan:
- SD addr 0x10, data 0x1122334455667788 from port 0, then LD 0x10 -> mem_wr_en at A+1 index 2; load rsp_rdata = 0x1122334455667788, rsp_valid[0] at A+3.
- SB 0xAB to 0x13 over that word -> RD, CAP, WR sequence; written word 0x11223344AB667788; LBU 0x13 = 0xAB; LB 0x13 = 0xFFFFFFFFFFFFFFAB.
- LW 0x12 (misaligned) -> rsp_err = 1, rsp_valid at A+1, no mem_rd_en/mem_wr_en.
- Both ports valid continuously, from reset -> grants alternate 0,1,0,1; each response carries the correct port bit.
- rst_n low during CAP of a sub-dword store -> no mem_wr_en; outputs 0 immediately; memory word unchanged.
- With RV_DMEM_BOUNDS_CHK_EN: LD 0x8000 (index 4096) -> rsp_err = 1. Without it: the access hits index 0.
